uart_fifo_bridge: RTL and testbench
===================================

Name: uart_fifo_bridge

Overview:
Synthesisable replacement for the ad-hoc read/process/write glue between the UART-RX FIFO and the UART-TX FIFO. Pops one word from the RX FIFO read port, applies a run-time-selectable transform (pass, add, subtract, XOR), and pushes the result into the TX FIFO write port. Honours TX-full backpressure without losing data, and provides transfer and stall counters for bring-up.

Parameters:
DATA_W, 8, word width of both FIFO data paths and of operand.
RD_LATENCY, 1, cycles from the rd_en edge to rx_dout valid (1..3).
GAP, 2, minimum IDLE cycles between consecutive transfers (0..15).
CNT_W, 16, width of xfer_count and stall_count.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous reset, active-high.
enable  in  1  allows new transfers to start.
mode  in  2  transform: 0 pass, 1 add operand, 2 subtract operand, 3 XOR operand.
operand  in  DATA_W  transform constant.
rx_empty  in  1  RX FIFO empty flag.
rx_rd_en  out  1  RX FIFO pop strobe.
rx_dout  in  DATA_W  RX FIFO read data.
tx_full  in  1  TX FIFO full flag.
tx_wr_en  out  1  TX FIFO push strobe.
tx_din  out  DATA_W  TX FIFO write data.
busy  out  1  high whenever state is not IDLE.
xfer_count  out  CNT_W  words pushed; wraps.
stall_count  out  CNT_W  WRITE cycles blocked by tx_full; saturates.

Behaviour:
- State machine: IDLE, READ, CAPTURE, WRITE. The state register is the only control state.
- Reset: state=IDLE, wait_cnt=0, result register=0, xfer_count=0, stall_count=0. Consequently rx_rd_en=0, tx_wr_en=0, tx_din=0 and busy=0.
- IDLE:
  - wait_cnt increments each cycle, saturating at GAP.
  - Go to READ at the edge where wait_cnt>=GAP, enable=1 and rx_empty=0. Otherwise stay.
  - With GAP=0, a non-empty FIFO is accepted on the first IDLE cycle.
- READ:
  - rx_rd_en=1, decoded from state, for exactly one cycle.
  - Unconditionally go to CAPTURE. rx_empty is not rechecked.
- CAPTURE:
  - Lasts exactly RD_LATENCY cycles, counted by an internal counter.
  - On the final edge, latch result = f(rx_dout). mode and operand are sampled on that same edge.
  - Go to WRITE.
- Transform: all arithmetic is modulo 2^DATA_W, with no carry or borrow output.
  - add: 0xFF+1=0x00.
  - subtract: 0x00-1=0xFF.
- tx_din always equals the result register.
- WRITE:
  - tx_wr_en = (state==WRITE) & ~tx_full. This is combinational on tx_full.
  - If tx_full=0: push this cycle, increment xfer_count, clear wait_cnt, go to IDLE.
  - If tx_full=1: hold in WRITE, keep result unchanged, and increment stall_count (saturating at all-ones).
- Throughput: minimum 3+RD_LATENCY+GAP cycles per word. With RD_LATENCY=1 and GAP=0 that is 4 cycles.
- enable deasserted mid-transfer: the in-flight word completes normally. No new READ starts until enable=1.
- Reset mid-transfer: immediate return to reset values. A word already popped from the RX FIFO is discarded by design.
- A word is never pushed twice and never dropped except by reset. tx_wr_en is never asserted while tx_full=1.
- rx_rd_en is never asserted while rx_empty was 1 at the deciding IDLE edge.

Test Plan:
- Pass-through: mode=0, GAP=0, RD_LATENCY=1, RX holds 0x41,0x42,0x43 -> TX receives 0x41,0x42,0x43 in order. Consecutive tx_wr_en pulses are 4 cycles apart; xfer_count=3; busy=0 afterwards.
- Increment with wrap: mode=1, operand=1, RX 0x41,0xFF -> TX 0x42,0x00. Then mode=2, operand=1, RX 0x00 -> TX 0xFF. Then mode=3, operand=0x0F, RX 0xA5 -> TX 0xAA.
- Backpressure: hold tx_full=1 for 5 cycles while in WRITE -> exactly one tx_wr_en after full drops. stall_count=5; tx_din stable throughout; next rx_rd_en only after the push.
- Gap and latency: GAP=2, RD_LATENCY=3, RX holds 2 words -> first rx_rd_en occurs 3 cycles after rx_empty falls. The push occurs 4 cycles after that rx_rd_en. Rising-edge spacing between tx_wr_en pulses is 3+RD_LATENCY+GAP = 8 cycles.
- Enable/empty: enable=0 with RX non-empty for 20 cycles -> no strobes, busy=0. rx_empty=1 throughout -> rx_rd_en stays 0. Deasserting enable during CAPTURE -> that word is still pushed, and no further pops follow.
- Reset mid-operation: assert rst for 1 cycle during CAPTURE -> next cycle state=IDLE with all outputs and counters 0, and no tx_wr_en for the lost word. Normal operation resumes on the next non-empty RX FIFO.

Source files
------------

// File: rtl/uart_fifo_bridge.sv
// Pops one word from the RX FIFO, applies a selectable transform and pushes it to the TX FIFO.
// Honours TX-full backpressure and keeps transfer/stall counters for bring-up.
module uart_fifo_bridge #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned GAP        = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] operand,
   input  logic              rx_empty,
   output logic              rx_rd_en,
   input  logic [DATA_W-1:0] rx_dout,
   input  logic              tx_full,
   output logic              tx_wr_en,
   output logic [DATA_W-1:0] tx_din,
   output logic              busy,
   output logic [CNT_W-1:0]  xfer_count,
   output logic [CNT_W-1:0]  stall_count
);

   typedef enum logic [1:0] {StIdle, StRead, StCapture, StWrite} state_e;

   localparam logic [3:0] GapVal  = 4'(GAP);
   localparam logic [1:0] LatLast = 2'(RD_LATENCY - 1);

   state_e            state_q, state_d;
   logic [3:0]        wait_q, wait_d;
   logic [1:0]        lat_q, lat_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] xform;
   logic [CNT_W-1:0]  xfer_q, xfer_d;
   logic [CNT_W-1:0]  stall_q, stall_d;

   // Arithmetic wraps modulo 2^DATA_W; carries and borrows are dropped.
   always_comb begin
      xform = rx_dout;
      unique case (mode)
         2'd0: xform = rx_dout;
         2'd1: xform = rx_dout + operand;
         2'd2: xform = rx_dout - operand;
         2'd3: xform = rx_dout ^ operand;
         default: xform = rx_dout;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      lat_d    = lat_q;
      result_d = result_q;
      xfer_d   = xfer_q;
      stall_d  = stall_q;
      rx_rd_en = 1'b0;
      tx_wr_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            // wait_q saturates at GAP, so equality means the gap has elapsed.
            if (wait_q != GapVal) begin
               wait_d = wait_q + 4'd1;
            end
            if ((wait_q == GapVal) && enable && !rx_empty) begin
               state_d = StRead;
            end
         end
         StRead: begin
            rx_rd_en = 1'b1;
            lat_d    = 2'd0;
            state_d  = StCapture;
         end
         StCapture: begin
            if (lat_q == LatLast) begin
               result_d = xform;
               state_d  = StWrite;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         StWrite: begin
            if (!tx_full) begin
               tx_wr_en = 1'b1;
               xfer_d   = xfer_q + 1'b1;
               wait_d   = 4'd0;
               state_d  = StIdle;
            end else if (stall_q != {CNT_W{1'b1}}) begin
               stall_d = stall_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         wait_q   <= 4'd0;
         lat_q    <= 2'd0;
         result_q <= '0;
         xfer_q   <= '0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         lat_q    <= lat_d;
         result_q <= result_d;
         xfer_q   <= xfer_d;
         stall_q  <= stall_d;
      end
   end

   assign tx_din      = result_q;
   assign busy        = (state_q != StIdle);
   assign xfer_count  = xfer_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: two instances (GAP=0/LAT=1 and GAP=2/LAT=3) fed by
// behavioural RX/TX FIFO models stepped one clock at a time.
module tb_uart_fifo_bridge;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       tx_full = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] operand = 8'd0;

   logic        rx_empty    [2];
   logic [7:0]  rx_dout     [2];
   logic        rx_rd_en    [2];
   logic        tx_wr_en    [2];
   logic [7:0]  tx_din      [2];
   logic        busy        [2];
   logic [15:0] xfer_count  [2];
   logic [15:0] stall_count [2];

   logic [7:0] rxq_a[$], rxq_b[$], txq_a[$], txq_b[$];
   int rd_log_a[$], wr_log_a[$], rd_log_b[$], wr_log_b[$];
   int cyc = 0;
   int cyc0;
   int bad_wr = 0;
   int bad_pop = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_fifo_bridge #(.DATA_W(8), .RD_LATENCY(1), .GAP(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .operand(operand),
      .rx_empty(rx_empty[0]), .rx_rd_en(rx_rd_en[0]), .rx_dout(rx_dout[0]),
      .tx_full(tx_full), .tx_wr_en(tx_wr_en[0]), .tx_din(tx_din[0]), .busy(busy[0]),
      .xfer_count(xfer_count[0]), .stall_count(stall_count[0])
   );

   uart_fifo_bridge #(.DATA_W(8), .RD_LATENCY(3), .GAP(2), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .operand(operand),
      .rx_empty(rx_empty[1]), .rx_rd_en(rx_rd_en[1]), .rx_dout(rx_dout[1]),
      .tx_full(tx_full), .tx_wr_en(tx_wr_en[1]), .tx_din(tx_din[1]), .busy(busy[1]),
      .xfer_count(xfer_count[1]), .stall_count(stall_count[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample strobes mid-cycle, then apply FIFO side effects just after the edge.
   task automatic tick();
      logic       rd_a, wr_a, rd_b, wr_b;
      logic [7:0] din_a, din_b;
      @(negedge clk);
      rd_a = rx_rd_en[0]; wr_a = tx_wr_en[0]; din_a = tx_din[0];
      rd_b = rx_rd_en[1]; wr_b = tx_wr_en[1]; din_b = tx_din[1];
      if ((wr_a === 1'b1 || wr_b === 1'b1) && tx_full) bad_wr++;
      @(posedge clk);
      #1;
      if (rd_a === 1'b1) begin
         rd_log_a.push_back(cyc);
         if (rxq_a.size() > 0) rx_dout[0] = rxq_a.pop_front();
         else bad_pop++;
      end
      if (rd_b === 1'b1) begin
         rd_log_b.push_back(cyc);
         if (rxq_b.size() > 0) rx_dout[1] = rxq_b.pop_front();
         else bad_pop++;
      end
      if (wr_a === 1'b1) begin wr_log_a.push_back(cyc); txq_a.push_back(din_a); end
      if (wr_b === 1'b1) begin wr_log_b.push_back(cyc); txq_b.push_back(din_b); end
      rx_empty[0] = (rxq_a.size() == 0);
      rx_empty[1] = (rxq_b.size() == 0);
      cyc++;
   endtask

   task automatic load_a(input logic [7:0] w);
      rxq_a.push_back(w);
      rx_empty[0] = 1'b0;
   endtask

   task automatic load_b(input logic [7:0] w);
      rxq_b.push_back(w);
      rx_empty[1] = 1'b0;
   endtask

   task automatic clear_logs();
      txq_a.delete(); txq_b.delete();
      rd_log_a.delete(); wr_log_a.delete(); rd_log_b.delete(); wr_log_b.delete();
   endtask

   task automatic run_until_a(input int n);
      for (int i = 0; i < 60 && txq_a.size() < n; i++) tick();
   endtask

   initial begin
      rx_empty[0] = 1'b1; rx_empty[1] = 1'b1;
      rx_dout[0]  = 8'h00; rx_dout[1]  = 8'h00;

      // Reset state
      tick(); tick();
      check("rst_rd_en",  32'(rx_rd_en[0]), 32'h0);
      check("rst_wr_en",  32'(tx_wr_en[0]), 32'h0);
      check("rst_tx_din", 32'(tx_din[0]), 32'h0);
      check("rst_busy",   32'(busy[0]), 32'h0);
      check("rst_xfer",   32'(xfer_count[0]), 32'h0);
      check("rst_stall",  32'(stall_count[0]), 32'h0);
      check("rst_busy_b", 32'(busy[1]), 32'h0);

      // Pass-through, back-to-back every 4 cycles
      rst = 1'b0; enable = 1'b1; mode = 2'd0;
      clear_logs();
      load_a(8'h41); load_a(8'h42); load_a(8'h43);
      run_until_a(3);
      check("pass_count", txq_a.size(), 32'd3);
      if (txq_a.size() == 3) begin
         check("pass_w0", 32'(txq_a[0]), 32'h41);
         check("pass_w1", 32'(txq_a[1]), 32'h42);
         check("pass_w2", 32'(txq_a[2]), 32'h43);
         check("pass_gap01", wr_log_a[1] - wr_log_a[0], 32'd4);
         check("pass_gap12", wr_log_a[2] - wr_log_a[1], 32'd4);
      end
      tick(); tick(); tick();
      check("pass_xfer", 32'(xfer_count[0]), 32'd3);
      check("pass_busy", 32'(busy[0]), 32'h0);

      // Transforms with wrap
      clear_logs();
      mode = 2'd1; operand = 8'h01;
      load_a(8'h41); load_a(8'hFF);
      run_until_a(2);
      check("add_count", txq_a.size(), 32'd2);
      if (txq_a.size() == 2) begin
         check("add_41", 32'(txq_a[0]), 32'h42);
         check("add_ff", 32'(txq_a[1]), 32'h00);
      end
      clear_logs();
      mode = 2'd2; operand = 8'h01;
      load_a(8'h00);
      run_until_a(1);
      check("sub_00", (txq_a.size() == 1) ? 32'(txq_a[0]) : 32'hDEAD, 32'hFF);
      clear_logs();
      mode = 2'd3; operand = 8'h0F;
      load_a(8'hA5);
      run_until_a(1);
      check("xor_a5", (txq_a.size() == 1) ? 32'(txq_a[0]) : 32'hDEAD, 32'hAA);

      // Backpressure: WRITE starts 3 cycles after the load, held full for 5 cycles
      clear_logs();
      mode = 2'd0; tx_full = 1'b1;
      cyc0 = cyc;
      load_a(8'h5A); load_a(8'h5B);
      tick(); tick(); tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_din_stable", 32'(tx_din[0]), 32'h5A);
         tick();
      end
      check("bp_no_push", txq_a.size(), 32'd0);
      check("bp_stall", 32'(stall_count[0]), 32'd5);
      check("bp_busy", 32'(busy[0]), 32'h1);
      tx_full = 1'b0;
      run_until_a(2);
      check("bp_count", txq_a.size(), 32'd2);
      if (txq_a.size() == 2) begin
         check("bp_w0", 32'(txq_a[0]), 32'h5A);
         check("bp_w1", 32'(txq_a[1]), 32'h5B);
         check("bp_push_cyc", wr_log_a[0] - cyc0, 32'd8);
         check("bp_next_rd", rd_log_a[1] - wr_log_a[0], 32'd2);
      end
      check("bp_stall_hold", 32'(stall_count[0]), 32'd5);

      // Enable low with data waiting; dut_b has seen only an empty FIFO so far
      clear_logs();
      enable = 1'b0;
      load_a(8'h11);
      for (int i = 0; i < 20; i++) tick();
      check("en0_no_rd", rd_log_a.size(), 32'd0);
      check("en0_no_wr", wr_log_a.size(), 32'd0);
      check("en0_busy", 32'(busy[0]), 32'h0);
      check("empty_no_rd_b", rd_log_b.size(), 32'd0);

      // Drop enable during CAPTURE: in-flight word completes, nothing else popped
      enable = 1'b1;
      tick(); tick();
      enable = 1'b0;
      load_a(8'h22);
      for (int i = 0; i < 15; i++) tick();
      check("en_drop_rd", rd_log_a.size(), 32'd1);
      check("en_drop_wr", (txq_a.size() == 1) ? 32'(txq_a[0]) : 32'hDEAD, 32'h11);
      check("en_drop_xfer", 32'(xfer_count[0]), 32'd10);

      // Reset during CAPTURE discards the popped 0x22
      clear_logs();
      enable = 1'b1;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy",  32'(busy[0]), 32'h0);
      check("mid_rst_rd",    32'(rx_rd_en[0]), 32'h0);
      check("mid_rst_wr",    32'(tx_wr_en[0]), 32'h0);
      check("mid_rst_din",   32'(tx_din[0]), 32'h0);
      check("mid_rst_xfer",  32'(xfer_count[0]), 32'h0);
      check("mid_rst_stall", 32'(stall_count[0]), 32'h0);
      for (int i = 0; i < 10; i++) tick();
      check("mid_rst_lost", txq_a.size(), 32'd0);
      load_a(8'h33);
      run_until_a(1);
      check("mid_rst_resume", (txq_a.size() == 1) ? 32'(txq_a[0]) : 32'hDEAD, 32'h33);
      check("mid_rst_xfer1", 32'(xfer_count[0]), 32'd1);

      // GAP=2, RD_LATENCY=3 instance, RX filled right out of reset
      mode = 2'd0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_logs();
      cyc0 = cyc;
      load_b(8'hC3); load_b(8'h3C);
      for (int i = 0; i < 60 && txq_b.size() < 2; i++) tick();
      check("gap_count", txq_b.size(), 32'd2);
      if (txq_b.size() == 2 && rd_log_b.size() == 2) begin
         check("gap_first_rd", rd_log_b[0] - cyc0, 32'd3);
         check("gap_rd_to_wr", wr_log_b[0] - rd_log_b[0], 32'd4);
         check("gap_wr_space", wr_log_b[1] - wr_log_b[0], 32'd8);
         check("gap_w0", 32'(txq_b[0]), 32'hC3);
         check("gap_w1", 32'(txq_b[1]), 32'h3C);
      end
      check("gap_xfer", 32'(xfer_count[1]), 32'd2);

      check("no_wr_while_full", bad_wr, 32'd0);
      check("no_pop_when_empty", bad_pop, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
